// File: rtl/gf2m_pkg.sv
// Shared encodings for the GF(2^m) digit-serial arithmetic unit:
// command opcodes, controller states and a constant log2 helper.
package gf2m_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_RSV2 = 2'b10,
        OP_RSV3 = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        WRITE
    } state_e;

    // Smallest r with (1 << r) >= v; usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2m_digit_seq_unit_if.sv
// Command/status bundle of the GF(2^m) unit.
// master: issues cmd_* and watches ready/busy/done/err; slave: the unit.
interface gf2m_digit_seq_unit_if #(
    parameter int AW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src_a;
    logic [AW-1:0] cmd_src_b;
    logic [AW-1:0] cmd_dst;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        output cmd_ready, busy, done, err
    );
endinterface

// File: rtl/gf2m_digit_step.sv
// One digit of MSB-first multiply-reduce in GF(2)[x]/f, f = x^m + f_low.
// In: acc, a (both < x^m), digit (MSB first), f (low terms), m. Out: acc_nxt.
module gf2m_digit_step #(
    parameter int DATA_W  = 256,
    parameter int DIGIT_W = 4,
    parameter int LW      = 9
) (
    input  logic [DATA_W-1:0]  acc,
    input  logic [DATA_W-1:0]  a,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [DATA_W-1:0]  f,
    input  logic [LW-1:0]      m,
    output logic [DATA_W-1:0]  acc_nxt
);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top_bit;
    logic [DATA_W-1:0] t;
    logic              top;

    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = (i < int'(m));
        end
        // One-hot at bit m-1: the term that overflows into x^m.
        top_bit = mask & ~(mask >> 1);
        t = acc;
        top = 1'b0;
        for (int i = DIGIT_W - 1; i >= 0; i--) begin
            top = |(t & top_bit);
            t = (t << 1) & mask;
            if (top) begin
                t = t ^ (f & mask);
            end
            if (digit[i]) begin
                t = t ^ a;
            end
        end
        acc_nxt = t;
    end
endmodule

// File: rtl/gf2m_digit_seq_unit.sv
// GF(2^m) ADD/MUL unit over a small register file, digit-serial multiply.
// Ports: clk, rst_n, regfile write (wr_*), registered read (rd_*),
// field poly/poly_len, and the cmd interface (handshake + busy/done/err).
module gf2m_digit_seq_unit
    import gf2m_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int DIGIT_W   = 4,
    parameter int REG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [clog2(REG_DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [clog2(REG_DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    input  logic [DATA_W-1:0]             poly,
    input  logic [clog2(DATA_W):0]        poly_len,
    gf2m_digit_seq_unit_if.slave          cmd
);
    localparam int AW = clog2(REG_DEPTH);
    localparam int LW = clog2(DATA_W) + 1;

    state_e            state;
    state_e            state_nxt;
    logic [DATA_W-1:0] rf [REG_DEPTH];
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] poly_r;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] acc_step;
    logic [LW-1:0]     m_r;
    logic [LW-1:0]     cnt_r;
    logic [LW-1:0]     n_m1;
    op_e               op_r;
    logic [AW-1:0]     sa_r;
    logic [AW-1:0]     sb_r;
    logic [AW-1:0]     dst_r;
    logic              bad_r;
    logic              bad_in;
    logic [DIGIT_W-1:0] digit;

    assign bad_in = (cmd.cmd_op != OP_ADD && cmd.cmd_op != OP_MUL)
                  || (poly_len == '0)
                  || (int'(poly_len) > DATA_W);

    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = (i < int'(m_r));
        end
        // Digit count minus one; the counter walks b from its top digit down.
        n_m1  = LW'((int'(m_r) + DIGIT_W - 1) / DIGIT_W - 1);
        digit = DIGIT_W'(b_r >> (int'(cnt_r) * DIGIT_W));
    end

    gf2m_digit_step #(
        .DATA_W  (DATA_W),
        .DIGIT_W (DIGIT_W),
        .LW      (LW)
    ) u_step (
        .acc     (acc_r),
        .a       (a_r),
        .digit   (digit),
        .f       (poly_r),
        .m       (m_r),
        .acc_nxt (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (bad_r) begin
                    state_nxt = IDLE;
                end else if (op_r == OP_MUL) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = WRITE;
                end
            end
            RUN: begin
                if (cnt_r == '0) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = (state != IDLE);
    assign cmd.done      = (state == WRITE) || (state == LOAD && bad_r);
    assign cmd.err       = (state == LOAD && bad_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                rf[i] <= '0;
            end
            rd_data <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            poly_r  <= '0;
            m_r     <= '0;
            cnt_r   <= '0;
            op_r    <= OP_ADD;
            sa_r    <= '0;
            sb_r    <= '0;
            dst_r   <= '0;
            bad_r   <= 1'b0;
        end else begin
            rd_data <= rf[rd_addr];
            // The unit's own result beats a same-cycle external write.
            if (wr_en && !(state == WRITE && wr_addr == dst_r)) begin
                rf[wr_addr] <= wr_data;
            end
            if (state == WRITE) begin
                rf[dst_r] <= acc_r;
            end
            if (state == IDLE && cmd.cmd_valid) begin
                op_r   <= op_e'(cmd.cmd_op);
                sa_r   <= cmd.cmd_src_a;
                sb_r   <= cmd.cmd_src_b;
                dst_r  <= cmd.cmd_dst;
                poly_r <= poly;
                m_r    <= poly_len;
                bad_r  <= bad_in;
            end
            if (state == LOAD) begin
                a_r   <= rf[sa_r] & mask;
                b_r   <= rf[sb_r] & mask;
                cnt_r <= n_m1;
                if (op_r == OP_ADD) begin
                    acc_r <= (rf[sa_r] ^ rf[sb_r]) & mask;
                end else begin
                    acc_r <= '0;
                end
            end
            if (state == RUN) begin
                acc_r <= acc_step;
                cnt_r <= cnt_r - LW'(1);
            end
        end
    end
endmodule

// File: tb/tb_gf2m_digit_seq_unit.sv
// Testbench for gf2m_digit_seq_unit: directed field cases plus random
// ADD/MUL traffic against a schoolbook multiply-then-reduce model.
module tb_gf2m_digit_seq_unit;
    localparam int DW = 256;
    localparam int DG = 4;
    localparam int RD = 8;
    localparam int AW = 3;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] poly = '0;
    logic [LW-1:0] poly_len = '0;

    logic [DW-1:0] model [RD];
    logic [DW-1:0] one;
    logic [DW-1:0] rv;
    int checks = 0;
    int errors = 0;

    gf2m_digit_seq_unit_if #(.AW(AW)) cif ();

    gf2m_digit_seq_unit #(
        .DATA_W    (DW),
        .DIGIT_W   (DG),
        .REG_DEPTH (RD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .poly     (poly),
        .poly_len (poly_len),
        .cmd      (cif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] mask_of(input int m);
        logic [DW-1:0] o;
        o = 1;
        return (o << m) - o;
    endfunction

    // Full carry-less product, then long division by x^m + p.
    function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [DW-1:0] p,
                                             input int m);
        logic [2*DW-1:0] prod;
        logic [2*DW-1:0] f;
        logic [2*DW-1:0] o;
        logic [DW-1:0]   mk;
        mk = mask_of(m);
        a = a & mk;
        b = b & mk;
        prod = '0;
        for (int i = 0; i < m; i++) begin
            if (b[i]) prod = prod ^ ({{DW{1'b0}}, a} << i);
        end
        o = 1;
        f = (o << m) | {{DW{1'b0}}, p & mk};
        for (int i = 2 * m - 2; i >= m; i--) begin
            if (prod[i]) prod = prod ^ (f << (i - m));
        end
        return prod[DW-1:0];
    endfunction

    task automatic ext_write(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic rd(input int a, output logic [DW-1:0] d);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic read_all(input string tag);
        logic [DW-1:0] d;
        for (int i = 0; i < RD; i++) begin
            rd(i, d);
            chk(tag, d, model[i]);
        end
    endtask

    task automatic op_run(input logic [1:0] op, input int sa, input int sb,
                          input int dst, input logic [DW-1:0] p,
                          input int m, input bit clob, input bit coll,
                          input bit nowait);
        logic [DW-1:0] res;
        logic [DW-1:0] clobv;
        bit bad;
        bit seen;
        bit e_seen;
        int exp_lat;
        int lat;
        bad = (op > 2'd1) || (m == 0) || (m > DW);
        res = '0;
        if (!bad) begin
            if (op == 2'd0) res = (model[sa] ^ model[sb]) & mask_of(m);
            else res = gf_mul(model[sa], model[sb], p, m);
        end
        exp_lat = bad ? 1 : (op == 2'd0 ? 2 : (m + DG - 1) / DG + 2);
        clobv = rnd256();
        if (!nowait) @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op = op;
        cif.cmd_src_a = AW'(sa);
        cif.cmd_src_b = AW'(sb);
        cif.cmd_dst = AW'(dst);
        poly = p;
        poly_len = LW'(m);
        chk("cmd_ready", cif.cmd_ready, 1);
        @(posedge clk);
        lat = 0;
        seen = 0;
        e_seen = 0;
        while (!seen && lat < 80) begin
            @(negedge clk);
            lat++;
            if (cif.done) begin
                seen = 1;
                e_seen = cif.err;
            end
            if (lat == 1) begin
                chk("busy", cif.busy, 1);
                cif.cmd_valid = 1'b0;
                cif.cmd_op = 2'($urandom);
                cif.cmd_src_a = AW'($urandom);
                cif.cmd_src_b = AW'($urandom);
                cif.cmd_dst = AW'($urandom);
                poly = rnd256();
                poly_len = LW'($urandom);
            end
            if (clob && lat == 2) begin
                wr_en = 1'b1;
                wr_addr = AW'(sa);
                wr_data = clobv;
            end
            if (clob && lat == 3) wr_en = 1'b0;
            if (seen && coll) begin
                wr_en = 1'b1;
                wr_addr = AW'(dst);
                wr_data = 256'hDEAD;
            end
        end
        chk("latency", lat, exp_lat);
        chk("err", e_seen, bad);
        @(negedge clk);
        wr_en = 1'b0;
        chk("done_pulse", cif.done, 0);
        if (clob) model[sa] = clobv;
        if (!bad) model[dst] = res;
        read_all("regfile");
    endtask

    initial begin
        int dn;
        one = 1;
        for (int i = 0; i < RD; i++) model[i] = '0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op = 2'd0;
        cif.cmd_src_a = '0;
        cif.cmd_src_b = '0;
        cif.cmd_dst = '0;

        #12;
        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_busy", cif.busy, 0);
        chk("rst_done", cif.done, 0);
        chk("rst_err", cif.err, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        read_all("init_rf");

        // m=4, f = x^4 + x + 1
        ext_write(0, 256'h7);
        ext_write(1, 256'hB);
        op_run(2'd1, 0, 1, 2, 256'h3, 4, 0, 0, 0);
        rd(2, rv);
        chk("m4_mul", rv, 256'h4);

        // m=163: x * x^162 reduces to the low terms of f
        ext_write(0, 256'h2);
        ext_write(1, one << 162);
        op_run(2'd1, 0, 1, 2, 256'hC9, 163, 0, 0, 0);
        rd(2, rv);
        chk("m163_mul", rv, 256'hC9);
        op_run(2'd0, 2, 2, 3, 256'hC9, 163, 0, 0, 0);
        rd(3, rv);
        chk("m163_add", rv, 256'h0);

        // squaring with out-of-field bits in the operand
        ext_write(0, 256'hFF);
        op_run(2'd1, 0, 0, 6, 256'h3, 4, 0, 0, 0);
        rd(6, rv);
        chk("m4_sq", rv, 256'hA);

        // rejected commands
        op_run(2'd1, 0, 1, 7, 256'h3, 0, 0, 0, 0);
        op_run(2'd3, 0, 1, 7, 256'h3, 4, 0, 0, 0);
        op_run(2'd0, 0, 1, 7, 256'h3, 257, 0, 0, 0);

        // external write colliding with the result write
        op_run(2'd0, 0, 1, 5, 256'h3, 4, 0, 1, 0);
        rd(5, rv);
        chk("collide", rv, 256'hF);

        // source overwritten while the multiply runs
        ext_write(0, rnd256());
        ext_write(1, rnd256());
        op_run(2'd1, 0, 1, 4, 256'hC9, 163, 1, 0, 0);

        // cmd_valid held through a busy operation
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op = 2'd0;
        cif.cmd_src_a = 3'd0;
        cif.cmd_src_b = 3'd1;
        cif.cmd_dst = 3'd4;
        poly = 256'h1B;
        poly_len = 9'd8;
        chk("hold_ready0", cif.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("hold_ready1", cif.cmd_ready, 0);
        cif.cmd_op = 2'd1;
        cif.cmd_src_a = 3'd4;
        cif.cmd_src_b = 3'd4;
        cif.cmd_dst = 3'd5;
        @(negedge clk);
        chk("hold_done", cif.done, 1);
        chk("hold_ready2", cif.cmd_ready, 0);
        @(negedge clk);
        chk("hold_idle_done", cif.done, 0);
        model[4] = (model[0] ^ model[1]) & mask_of(8);
        op_run(2'd1, 4, 4, 5, 256'h1B, 8, 0, 0, 1);

        // random traffic
        for (int it = 0; it < 8; it++) begin
            int m;
            logic [1:0] op;
            ext_write($urandom_range(0, RD - 1), rnd256());
            ext_write($urandom_range(0, RD - 1), rnd256());
            m = (it % 2 == 1) ? $urandom_range(1, DW) : $urandom_range(1, 16);
            op = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1;
            op_run(op, $urandom_range(0, RD - 1), $urandom_range(0, RD - 1),
                   $urandom_range(0, RD - 1), rnd256(), m,
                   (op == 2'd1 && it % 3 == 0), 0, 0);
        end

        // reset in the middle of a multiply
        ext_write(0, 256'h2);
        ext_write(1, one << 162);
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op = 2'd1;
        cif.cmd_src_a = 3'd0;
        cif.cmd_src_b = 3'd1;
        cif.cmd_dst = 3'd2;
        poly = 256'hC9;
        poly_len = 9'd163;
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("run_busy", cif.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", cif.busy, 0);
        chk("abort_ready", cif.cmd_ready, 1);
        chk("abort_done", cif.done, 0);
        chk("abort_err", cif.err, 0);
        chk("abort_rd", rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cif.done) dn++;
        end
        chk("abort_no_done", dn, 0);
        for (int i = 0; i < RD; i++) model[i] = '0;
        read_all("abort_rf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
